// File: rtl/jk_reg_counter.sv
// jk_reg_counter: a bank of WIDTH JK cells that can also act as a
// synchronous up/down counter or a parallel-load register. Clear beats
// preset, preset beats the enabled mode operation. tc flags the terminal
// count for the selected direction; wrap pulses for one cycle after the
// count rolls over.
module jk_reg_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             wrap
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] up_toggle;
    logic [WIDTH-1:0] down_toggle;

    // Toggle chains: a cell flips when every lower cell is 1 (up) or 0 (down)
    always_comb begin
        up_toggle      = '0;
        down_toggle    = '0;
        up_toggle[0]   = 1'b1;
        down_toggle[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_toggle[i]   = up_toggle[i-1] & q_q[i-1];
            down_toggle[i] = down_toggle[i-1] & ~q_q[i-1];
        end
    end

    // Terminal count depends only on the held state and the direction, never on en
    always_comb begin
        tc = 1'b0;
        if (mode == MODE_UP) begin
            tc = &q_q;
        end else if (mode == MODE_DOWN) begin
            tc = ~|q_q;
        end
    end

    // Next state: preset first, then the enabled mode; wrap only on an enabled roll-over
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (pr) begin
            q_d = '1;
        end else if (en) begin
            case (mode)
                MODE_JK:   q_d = (j & ~q_q) | (~k & q_q);
                MODE_UP:   q_d = q_q ^ up_toggle;
                MODE_DOWN: q_d = q_q ^ down_toggle;
                MODE_LOAD: q_d = j;
                default:   q_d = q_q;
            endcase
            wrap_d = tc;
        end
    end

    // State register with synchronous clear taking priority over everything
    always_ff @(posedge clk) begin
        if (clr) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign qn   = ~q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_reg_counter.sv
// Directed testbench for jk_reg_counter at WIDTH=4: reset/preset priority,
// JK cell rules, up/down counting with wrap, load and hold behaviour.
module tb_jk_reg_counter;

    logic       clk;
    logic       clr;
    logic       pr;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
    logic [3:0] qn;
    logic       tc;
    logic       wrap;

    int testCount;
    int failCount;

    jk_reg_counter #(.WIDTH(4)) dut (
        .clk  (clk),
        .clr  (clr),
        .pr   (pr),
        .en   (en),
        .mode (mode),
        .j    (j),
        .k    (k),
        .q    (q),
        .qn   (qn),
        .tc   (tc),
        .wrap (wrap)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one set of inputs, then let one rising edge pass and settle
    task automatic applyStimulus(input logic iClr, input logic iPr, input logic iEn,
                                 input logic [1:0] iMode, input logic [3:0] iJ,
                                 input logic [3:0] iK);
        clr  = iClr;
        pr   = iPr;
        en   = iEn;
        mode = iMode;
        j    = iJ;
        k    = iK;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against hand-computed values
    task automatic checkOutput(input string tag, input logic [3:0] expQ,
                               input logic expTc, input logic expWrap);
        logic [3:0] expQn;
        expQn = ~expQ;
        testCount++;
        assert (q === expQ) else begin
            failCount++;
            $error("[TB] FAIL %s q: observed %b expected %b", tag, q, expQ);
        end
        testCount++;
        assert (qn === expQn) else begin
            failCount++;
            $error("[TB] FAIL %s qn: observed %b expected %b", tag, qn, expQn);
        end
        testCount++;
        assert (tc === expTc) else begin
            failCount++;
            $error("[TB] FAIL %s tc: observed %b expected %b", tag, tc, expTc);
        end
        testCount++;
        assert (wrap === expWrap) else begin
            failCount++;
            $error("[TB] FAIL %s wrap: observed %b expected %b", tag, wrap, expWrap);
        end
    endtask

    initial begin
        logic [3:0] expQ;
        testCount = 0;
        failCount = 0;
        clr  = 1'b0;
        pr   = 1'b0;
        en   = 1'b0;
        mode = 2'b00;
        j    = 4'b0000;
        k    = 4'b0000;
        @(negedge clk);

        // Clear, preset, then both together (clear wins)
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        checkOutput("clr", 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000);
        checkOutput("preset", 4'b1111, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000);
        checkOutput("clr_beats_pr", 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 4'b0000, 4'b0000);
        checkOutput("clr_mode_down_tc", 4'b0000, 1'b1, 1'b0);

        // JK cell rules
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 4'b1010, 4'b0101);
        checkOutput("jk_set_clear", 4'b1010, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 4'b1111, 4'b1111);
        checkOutput("jk_toggle", 4'b0101, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 4'b0000);
        checkOutput("jk_hold", 4'b0101, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 4'b0011, 4'b0110);
        checkOutput("jk_mixed", 4'b0011, 1'b0, 1'b0);

        // Count up 17 edges from zero: wrap pulses once after 1111 -> 0000
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b01, 4'b0000, 4'b0000);
        for (int i = 0; i < 17; i++) begin
            expQ = 4'((i + 1) % 16);
            applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000);
            checkOutput($sformatf("up_%0d", i), expQ, (expQ == 4'b1111), (i == 15));
        end

        // Count down from 0010 across the zero boundary
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 4'b0010, 4'b0000);
        checkOutput("load_0010", 4'b0010, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000);
        checkOutput("down_0001", 4'b0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000);
        checkOutput("down_0000", 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000);
        checkOutput("down_1111", 4'b1111, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000);
        checkOutput("down_1110", 4'b1110, 1'b0, 1'b0);

        // Load then hold with en low while j keeps changing
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 4'b0110, 4'b0000);
        checkOutput("load_0110", 4'b0110, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 4'b1001, 4'b1111);
        checkOutput("hold_a", 4'b0110, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 4'b1111, 4'b0000);
        checkOutput("hold_b", 4'b0110, 1'b0, 1'b0);

        // tc ignores en; disabled edge at terminal count gives no wrap
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 4'b1111, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 4'b0000, 4'b0000);
        checkOutput("tc_en_low", 4'b1111, 1'b1, 1'b0);

        // Clear on the wrap edge abandons the count and suppresses wrap
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000);
        checkOutput("clr_on_wrap", 4'b0000, 1'b0, 1'b0);

        // Preset beats an enabled down count at zero and suppresses wrap
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 4'b0000, 4'b0000);
        checkOutput("pr_on_wrap", 4'b1111, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
